// File: rtl/cache_wb_queue_if.sv
// Port bundle for the writeback queue: eviction input, memory write-beat output,
// pending-line lookup and occupancy status.
interface cache_wb_queue_if #(
  parameter int LINE_SIZE       = 64,
  parameter int MEM_DATA_SIZE   = 16,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int DEPTH           = 4
) ();
  localparam int BEATS = LINE_SIZE / MEM_DATA_SIZE;
  localparam int BW    = $clog2(BEATS);

  logic                              evict_valid;
  logic [LINE_ADDR_WIDTH-1:0]        evict_addr;
  logic [LINE_SIZE*8-1:0]            evict_data;
  logic [LINE_SIZE-1:0]              evict_byteen;
  logic                              evict_ready;

  logic                              mem_req_valid;
  logic [LINE_ADDR_WIDTH+BW-1:0]     mem_req_addr;
  logic [MEM_DATA_SIZE*8-1:0]        mem_req_data;
  logic [MEM_DATA_SIZE-1:0]          mem_req_byteen;
  logic                              mem_req_last;
  logic                              mem_req_ready;

  logic [LINE_ADDR_WIDTH-1:0]        lookup_addr;
  logic                              lookup_hit;
  logic                              empty;

  // Queue side.
  modport slave (
    input  evict_valid, evict_addr, evict_data, evict_byteen, mem_req_ready, lookup_addr,
    output evict_ready, mem_req_valid, mem_req_addr, mem_req_data, mem_req_byteen,
    output mem_req_last, lookup_hit, empty
  );

  // Cache bank / memory side.
  modport master (
    output evict_valid, evict_addr, evict_data, evict_byteen, mem_req_ready, lookup_addr,
    input  evict_ready, mem_req_valid, mem_req_addr, mem_req_data, mem_req_byteen,
    input  mem_req_last, lookup_hit, empty
  );
endinterface

// File: rtl/cache_wb_queue.sv
// Writeback queue: buffers evicted dirty lines and serialises them into memory
// write beats, skipping beats with no dirty bytes.
module cache_wb_queue #(
  parameter int LINE_SIZE       = 64,
  parameter int MEM_DATA_SIZE   = 16,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int DEPTH           = 4
) (
  input  logic            clk,
  input  logic            reset,
  cache_wb_queue_if.slave bus
);
  localparam int BEATS = LINE_SIZE / MEM_DATA_SIZE;
  localparam int BW    = $clog2(BEATS);
  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = LINE_SIZE * 8;
  localparam int MW    = MEM_DATA_SIZE * 8;

  typedef enum logic {IDLE, SEND} state_e;

  logic [LINE_ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [LW-1:0]              data_q [DEPTH];
  logic [LINE_SIZE-1:0]       be_q   [DEPTH];
  logic [DEPTH-1:0]           vld_q;
  logic [PW-1:0]              wptr, rptr, rptr_n;
  logic [PW:0]                count, held;
  state_e                     state;
  logic [BW-1:0]              bidx;

  logic                       push, store, hs, pop, enter, beat_last, hit;
  logic [BEATS-1:0]           head_mask;
  logic [LINE_SIZE-1:0]       next_head_be;

  function automatic logic [BEATS-1:0] beat_mask(input logic [LINE_SIZE-1:0] be);
    logic [BEATS-1:0] m;
    for (int b = 0; b < BEATS; b++) m[b] = |be[b*MEM_DATA_SIZE +: MEM_DATA_SIZE];
    return m;
  endfunction

  // Lowest beat index >= from with a nonzero byte-enable slice.
  function automatic logic [BW-1:0] next_beat(input logic [BEATS-1:0] m, input int from);
    logic [BW-1:0] r;
    r = '0;
    for (int b = BEATS - 1; b >= 0; b--) if (b >= from && m[b]) r = BW'(b);
    return r;
  endfunction

  function automatic logic has_after(input logic [BEATS-1:0] m, input logic [BW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int b = 0; b < BEATS; b++) if (b > int'(idx) && m[b]) r = 1'b1;
    return r;
  endfunction

  assign head_mask = beat_mask(be_q[rptr]);
  assign beat_last = !has_after(head_mask, bidx);
  assign push      = bus.evict_valid && bus.evict_ready;
  assign store     = push && (|bus.evict_byteen);
  assign hs        = (state == SEND) && bus.mem_req_ready;
  assign pop       = hs && beat_last;
  assign rptr_n    = rptr + PW'(pop);
  assign held      = count - (PW+1)'(pop);
  assign enter     = ((state == IDLE) || pop) && ((held != '0) || store);
  // A line written this very cycle is not in the array yet, so take its mask from the port.
  assign next_head_be = (held != '0) ? be_q[rptr_n] : bus.evict_byteen;

  assign bus.evict_ready    = (count != (PW+1)'(DEPTH));
  assign bus.empty          = (count == '0);
  assign bus.mem_req_valid  = (state == SEND);
  assign bus.mem_req_addr   = {addr_q[rptr], bidx};
  assign bus.mem_req_data   = data_q[rptr][bidx*MW +: MW];
  assign bus.mem_req_byteen = be_q[rptr][bidx*MEM_DATA_SIZE +: MEM_DATA_SIZE];
  assign bus.mem_req_last   = beat_last;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (vld_q[i] && addr_q[i] == bus.lookup_addr) hit = 1'b1;
  end
  assign bus.lookup_hit = hit;

  always_ff @(posedge clk) begin
    if (store) begin
      addr_q[wptr] <= bus.evict_addr;
      data_q[wptr] <= bus.evict_data;
      be_q[wptr]   <= bus.evict_byteen;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vld_q <= '0;
      bidx  <= '0;
      state <= IDLE;
    end else begin
      if (store) wptr <= wptr + 1'b1;
      rptr  <= rptr_n;
      count <= held + (PW+1)'(store);
      if (pop)   vld_q[rptr] <= 1'b0;
      if (store) vld_q[wptr] <= 1'b1;
      case (state)
        IDLE: if (enter) begin
          state <= SEND;
          bidx  <= next_beat(beat_mask(next_head_be), 0);
        end
        SEND: if (hs) begin
          if (!beat_last) bidx <= next_beat(head_mask, int'(bidx) + 1);
          else if (enter) bidx <= next_beat(beat_mask(next_head_be), 0);
          else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    push |-> (count != (PW+1)'(DEPTH)));

  a_req_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.mem_req_valid && !bus.mem_req_ready) |=>
      (bus.mem_req_valid && $stable(bus.mem_req_addr) && $stable(bus.mem_req_data) &&
       $stable(bus.mem_req_byteen) && $stable(bus.mem_req_last)));
endmodule

// File: tb/tb_cache_wb_queue.sv
// Directed bench for cache_wb_queue with a scoreboard monitor on the write-beat port.
module tb_cache_wb_queue;
  typedef struct packed {
    logic [27:0]  addr;
    logic [127:0] data;
    logic [15:0]  be;
    logic         last;
  } beat_t;

  logic  clk = 1'b0;
  logic  reset;
  beat_t exp_q[$];
  beat_t held_beat;
  logic  stall_prev = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_hs  = 0;
  int    hs0;
  logic  ready_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  cache_wb_queue_if #(.LINE_SIZE(64), .MEM_DATA_SIZE(16), .LINE_ADDR_WIDTH(26), .DEPTH(2)) bus ();

  cache_wb_queue #(.LINE_SIZE(64), .MEM_DATA_SIZE(16), .LINE_ADDR_WIDTH(26), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [511:0] line_pat(input int base);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = 8'(base + i);
    return r;
  endfunction

  function automatic logic [127:0] beat_pat(input int base);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(base + i);
    return r;
  endfunction

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [27:0] a, input int base, input logic [15:0] be,
                             input logic last);
    beat_t b;
    b.addr = a;
    b.data = beat_pat(base);
    b.be   = be;
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic evict(input logic [25:0] a, input int base, input logic [63:0] be);
    bus.evict_valid  = 1'b1;
    bus.evict_addr   = a;
    bus.evict_data   = line_pat(base);
    bus.evict_byteen = be;
  endtask

  // Scoreboard monitor: samples mid-cycle, pops on every handshake, checks holds on stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk1("hold_valid", bus.mem_req_valid, 1'b1);
          chkw("hold_addr", 128'(bus.mem_req_addr), 128'(held_beat.addr));
          chkw("hold_data", bus.mem_req_data, held_beat.data);
          chkw("hold_byteen", 128'(bus.mem_req_byteen), 128'(held_beat.be));
          chk1("hold_last", bus.mem_req_last, held_beat.last);
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          n_hs++;
          stall_prev = 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got addr %0h, expected no beat", bus.mem_req_addr);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            chkw("beat_addr", 128'(bus.mem_req_addr), 128'(e.addr));
            chkw("beat_data", bus.mem_req_data, e.data);
            chkw("beat_byteen", 128'(bus.mem_req_byteen), 128'(e.be));
            chk1("beat_last", bus.mem_req_last, e.last);
          end
        end else if (bus.mem_req_valid) begin
          stall_prev = 1'b1;
          held_beat.addr = bus.mem_req_addr;
          held_beat.data = bus.mem_req_data;
          held_beat.be   = bus.mem_req_byteen;
          held_beat.last = bus.mem_req_last;
        end else begin
          stall_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.evict_valid   = 1'b0;
    bus.evict_addr    = '0;
    bus.evict_data    = '0;
    bus.evict_byteen  = '0;
    bus.mem_req_ready = 1'b0;
    bus.lookup_addr   = '0;
    step();
    step();
    chk1("rst_valid", bus.mem_req_valid, 1'b0);
    chk1("rst_empty", bus.empty, 1'b1);
    chk1("rst_hit", bus.lookup_hit, 1'b0);
    chk1("rst_evict_ready", bus.evict_ready, 1'b1);
    reset = 1'b0;
    step();

    // Full line, memory always ready
    bus.mem_req_ready = 1'b1;
    bus.lookup_addr   = 26'h10;
    evict(26'h10, 0, {64{1'b1}});
    for (int k = 0; k < 4; k++) expect_beat(28'h40 + 28'(k), 16*k, 16'hFFFF, k == 3);
    step();
    bus.evict_valid = 1'b0;
    chk1("t1_first_valid", bus.mem_req_valid, 1'b1);
    chk1("t1_hit", bus.lookup_hit, 1'b1);
    step();
    step();
    step();
    chk1("t1_hit_last_beat", bus.lookup_hit, 1'b1);
    step();
    chk1("t1_empty_after", bus.empty, 1'b1);
    chk1("t1_valid_after", bus.mem_req_valid, 1'b0);
    chk1("t1_hit_after", bus.lookup_hit, 1'b0);

    // Sparse line: only beat 2 dirty
    evict(26'h7, 0, 64'h0000_FFFF_0000_0000);
    expect_beat(28'h1E, 32, 16'hFFFF, 1'b1);
    step();
    bus.evict_valid = 1'b0;
    chk1("t2_valid", bus.mem_req_valid, 1'b1);
    chk1("t2_last", bus.mem_req_last, 1'b1);
    step();
    chk1("t2_empty", bus.empty, 1'b1);
    chk1("t2_valid_after", bus.mem_req_valid, 1'b0);

    // Clean eviction is swallowed
    bus.lookup_addr = 26'h55;
    evict(26'h55, 0, 64'h0);
    #1;
    chk1("t3_evict_ready", bus.evict_ready, 1'b1);
    step();
    bus.evict_valid = 1'b0;
    chk1("t3_empty", bus.empty, 1'b1);
    chk1("t3_valid", bus.mem_req_valid, 1'b0);
    chk1("t3_hit", bus.lookup_hit, 1'b0);
    step();
    chk1("t3_valid_later", bus.mem_req_valid, 1'b0);

    // Fill while memory stalls, then drain back-to-back
    bus.mem_req_ready = 1'b0;
    evict(26'h10, 0, {64{1'b1}});
    step();
    evict(26'h20, 64, {64{1'b1}});
    step();
    bus.evict_valid = 1'b0;
    for (int k = 0; k < 4; k++) expect_beat(28'h40 + 28'(k), 16*k, 16'hFFFF, k == 3);
    for (int k = 0; k < 4; k++) expect_beat(28'h80 + 28'(k), 64 + 16*k, 16'hFFFF, k == 3);
    chk1("t4_evict_ready_full", bus.evict_ready, 1'b0);
    chk1("t4_not_empty", bus.empty, 1'b0);
    bus.lookup_addr = 26'h20;
    #1;
    chk1("t4_hit_20", bus.lookup_hit, 1'b1);
    bus.lookup_addr = 26'h30;
    #1;
    chk1("t4_hit_30", bus.lookup_hit, 1'b0);
    bus.lookup_addr   = 26'h10;
    bus.mem_req_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk1("t4_no_gap", bus.mem_req_valid, 1'b1);
      if (i == 3) chk1("t4_hit_10_last", bus.lookup_hit, 1'b1);
      if (i == 4) chk1("t4_hit_10_cleared", bus.lookup_hit, 1'b0);
      step();
    end
    chk1("t4_empty", bus.empty, 1'b1);

    // Intermittent ready
    evict(26'h3, 128, {64{1'b1}});
    for (int k = 0; k < 4; k++) expect_beat(28'hC + 28'(k), 128 + 16*k, 16'hFFFF, k == 3);
    hs0 = n_hs;
    step();
    bus.evict_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.mem_req_ready = ready_pat[i];
      step();
    end
    chkw("t5_handshakes", 128'(n_hs - hs0), 128'(4));
    chk1("t5_empty", bus.empty, 1'b1);
    chk1("t5_valid_after", bus.mem_req_valid, 1'b0);

    // Reset in the middle of a line with another queued
    bus.mem_req_ready = 1'b1;
    evict(26'h21, 192, {64{1'b1}});
    expect_beat(28'h84, 192, 16'hFFFF, 1'b0);
    expect_beat(28'h85, 208, 16'hFFFF, 1'b0);
    step();
    evict(26'h22, 0, {64{1'b1}});
    step();
    bus.evict_valid = 1'b0;
    step();
    chkw("t6_beat2_addr", 128'(bus.mem_req_addr), 128'(28'h86));
    reset = 1'b1;
    bus.mem_req_ready = 1'b0;
    step();
    chk1("t6_valid", bus.mem_req_valid, 1'b0);
    chk1("t6_empty", bus.empty, 1'b1);
    chk1("t6_evict_ready", bus.evict_ready, 1'b1);
    bus.lookup_addr = 26'h21;
    #1;
    chk1("t6_hit_21", bus.lookup_hit, 1'b0);
    bus.lookup_addr = 26'h22;
    #1;
    chk1("t6_hit_22", bus.lookup_hit, 1'b0);
    reset = 1'b0;
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk1("t6_valid_later", bus.mem_req_valid, 1'b0);
    chkw("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
